// File: rtl/signmag_to_twos_serial_if.sv
// Handshake bundle for the sign/magnitude to two's-complement converter.
// in_* carries operands in, out_* carries results out; valid/ready on each side.
interface signmag_to_twos_serial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_err;

  modport master (
    output in_valid, in_sign, in_mag, out_ready,
    input  in_ready, out_valid, out, out_err
  );

  modport slave (
    input  in_valid, in_sign, in_mag, out_ready,
    output in_ready, out_valid, out, out_err
  );
endinterface

// File: rtl/signmag_to_twos_serial.sv
// Rebuilds a two's-complement value from sign + magnitude, negating bit-serially
// LSB first (copy through first 1, then invert). Ports: clk, reset, bus (slave).
module signmag_to_twos_serial #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  signmag_to_twos_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COPY, INV, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_q;
  logic             sign_q;
  logic             err_q;
  logic             out_err_q;
  logic [CW-1:0]    cnt;
  logic             res_bit;
  logic             last;
  logic             accept;
  logic             busy;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && (state == IDLE);
  assign busy   = (state == COPY) || (state == INV);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    res_bit  = sh[0];
    unique case (state)
      IDLE: if (accept) state_nx = COPY;
      COPY: begin
        res_bit = sh[0];
        if (last)
          state_nx = DONE;
        else if (sign_q && sh[0])
          state_nx = INV;
      end
      INV: begin
        res_bit = ~sh[0];
        if (last) state_nx = DONE;
      end
      DONE: if (bus.out_ready) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      res       <= '0;
      out_q     <= '0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sh     <= bus.in_mag;
        sign_q <= bus.in_sign;
        res    <= '0;
        cnt    <= '0;
        err_q  <= (!bus.in_sign && bus.in_mag[WIDTH-1]) ||
                  (bus.in_sign && (bus.in_mag > MIN_MAG));
      end else if (busy) begin
        // result bits enter at the MSB so bit 0 lands at the bottom after WIDTH shifts
        sh  <= sh >> 1;
        res <= {res_bit, res[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        // publish only the complete word, never a partial one
        if (last) begin
          out_q     <= {res_bit, res[WIDTH-1:1]};
          out_err_q <= err_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_signmag_to_twos_serial.sv
// Self-checking bench for signmag_to_twos_serial (WIDTH=4): vector table,
// hand-written corner sequences, abs round-trip and random ops vs a model.
module tb_signmag_to_twos_serial;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  signmag_to_twos_serial_if #(.WIDTH(W)) bus ();

  signmag_to_twos_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] m;
    logic [W-1:0] o;
    logic         e;
    string        nm;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [W-1:0] m,
                                output logic [W-1:0] o, output logic e);
    int mv;
    int half;
    mv   = int'(m);
    half = 1 << (W - 1);
    o    = s ? W'(((1 << W) - mv) % (1 << W)) : m;
    e    = s ? (mv > half) : (mv >= half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one operand, measure latency, optionally stall, then drain
  task automatic run_op(input logic s, input logic [W-1:0] m,
                        input logic [W-1:0] eo, input logic ee,
                        input int hold, input string nm);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_mag   = m;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_lat"}, 32'(n), 32'(W));
    for (int i = 0; i < hold; i++) tick();
    check({nm, "_out"}, 32'(bus.out), 32'(eo));
    check({nm, "_err"}, 32'(bus.out_err), 32'(ee));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] eo;
    logic         ee;
    logic         rs;
    logic [W-1:0] rm;

    tbl[0] = '{1'b0, 4'd3, 4'b0011, 1'b0, "p3"};
    tbl[1] = '{1'b1, 4'd4, 4'b1100, 1'b0, "n4"};
    tbl[2] = '{1'b1, 4'd6, 4'b1010, 1'b0, "n6"};
    tbl[3] = '{1'b1, 4'd1, 4'b1111, 1'b0, "n1"};
    tbl[4] = '{1'b1, 4'd0, 4'b0000, 1'b0, "negzero"};
    tbl[5] = '{1'b1, 4'd8, 4'b1000, 1'b0, "n8"};
    tbl[6] = '{1'b0, 4'd8, 4'b1000, 1'b1, "p8_err"};
    tbl[7] = '{1'b1, 4'd9, 4'b0111, 1'b1, "n9_err"};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_mag    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_err", 32'(bus.out_err), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].s, tbl[i].m, tbl[i].o, tbl[i].e, 0, tbl[i].nm);

    // back-pressure: result held, stray in_valid ignored
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_mag   = 4'd6;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    check("bp_valid0", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_mag   = 4'd2;
      end
      tick();
      bus.in_valid = 1'b0;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out", 32'(bus.out), 32'b1010);
      check("bp_err", 32'(bus.out_err), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    check("bp_release_vld", 32'(bus.out_valid), 32'd0);
    check("bp_out_kept", 32'(bus.out), 32'b1010);
    tick();
    check("bp_no_ghost", 32'(bus.in_ready), 32'd1);

    // reset during processing
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_mag   = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_err", 32'(bus.out_err), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    run_op(1'b1, 4'd5, 4'b1011, 1'b0, 0, "after_rst_n5");

    // reset while holding a finished result
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_mag   = 4'd3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();
    check("done_hold_vld", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("done_rst_valid", 32'(bus.out_valid), 32'd0);
    check("done_rst_out", 32'(bus.out), 32'd0);
    check("done_rst_ready", 32'(bus.in_ready), 32'd1);

    // abs round trip over every signed value
    for (int v = -(1 << (W - 1)); v < (1 << (W - 1)); v++) begin
      rs = (v < 0);
      rm = rs ? W'(-v) : W'(v);
      run_op(rs, rm, W'(v), 1'b0, 0, $sformatf("rt%0d", v));
    end

    // random operands with random stall lengths
    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(1));
      rm = W'($urandom_range((1 << W) - 1));
      model(rs, rm, eo, ee);
      run_op(rs, rm, eo, ee, int'($urandom_range(3)),
             $sformatf("rnd%0d_s%0d_m%0d", k, rs, rm));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
